// File: rtl/fc_layer_par.sv
// Fully-connected layer engine: y = act(W*x + b), P rows per pass over N columns.
// Coefficients sit in per-lane RAM banks, with row r held in bank r%P, loaded through the cfg port.
module fc_layer_par #(
   parameter int M     = 8,
   parameter int N     = 8,
   parameter int T     = 16,
   parameter int P     = 2,
   parameter int FRAC  = 0,
   parameter int RELU  = 1,
   parameter int ACC_W = 2*T + $clog2(N)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [T-1:0]           data_in,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [T-1:0]           data_out,
   input  logic                   cfg_we,
   input  logic                   cfg_sel,
   input  logic [$clog2(M*N)-1:0] cfg_addr,
   input  logic [T-1:0]           cfg_data,
   output logic                   busy
);

   localparam int G   = M / P;
   localparam int CW  = $clog2(N + 2);
   localparam int XAW = (N > 1) ? $clog2(N) : 1;
   localparam int GW  = (G > 1) ? $clog2(G) : 1;
   localparam int LW  = (P > 1) ? $clog2(P) : 1;
   localparam int BAW = (G*N > 1) ? $clog2(G*N) : 1;

   localparam logic [CW-1:0] CNT_XLAST = CW'(N - 1);
   localparam logic [CW-1:0] CNT_N     = CW'(N);
   localparam logic [CW-1:0] CNT_CLAST = CW'(N + 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [GW-1:0] GRP_LAST  = GW'(G - 1);
   localparam logic [LW-1:0] LANE_LAST = LW'(P - 1);

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef enum logic [1:0] {LOAD_X, COMPUTE, OUTPUT} state_t;

   localparam acc_t SAT_MAX = {{(ACC_W-T+1){1'b0}}, {(T-1){1'b1}}};
   localparam acc_t SAT_MIN = {{(ACC_W-T+1){1'b1}}, {(T-1){1'b0}}};

   function automatic logic [T-1:0] fmt(input acc_t a);
      acc_t s;
      s = a >>> FRAC;
      if (RELU != 0 && s < 0) s = '0;
      if (s > SAT_MAX) s = SAT_MAX;
      if (s < SAT_MIN) s = SAT_MIN;
      return s[T-1:0];
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [GW-1:0]   grp_q, grp_d;
   logic [LW-1:0]   lane_q, lane_d;
   logic            busy_q, busy_d;
   logic            m_valid_q, m_valid_d;
   logic [T-1:0]    data_out_q, data_out_d;
   logic            x_we;
   logic [XAW-1:0]  rd_col;
   logic [BAW-1:0]  w_raddr;
   logic signed [T-1:0] x_mem [N];
   logic signed [T-1:0] x_rd;
   logic [T-1:0]    res [P];

   int              cfg_row, cfg_col, w_bank, b_bank;
   logic            w_hit, b_hit;
   logic [BAW-1:0]  w_waddr;
   logic [GW-1:0]   b_waddr;

   assign s_ready  = (state_q == LOAD_X) && !reset;
   assign m_valid  = m_valid_q;
   assign data_out = data_out_q;
   assign busy     = busy_q;

   // Coefficient write decode: flat row-major address onto (bank, bank address).
   always_comb begin
      cfg_row = int'(cfg_addr) / N;
      cfg_col = int'(cfg_addr) % N;
      w_bank  = cfg_row % P;
      b_bank  = int'(cfg_addr) % P;
      w_waddr = BAW'((cfg_row / P) * N + cfg_col);
      b_waddr = GW'(int'(cfg_addr) / P);
      w_hit   = cfg_we && !busy_q && !cfg_sel && (int'(cfg_addr) < M*N);
      b_hit   = cfg_we && !busy_q &&  cfg_sel && (int'(cfg_addr) < M);
   end

   assign rd_col  = (cnt_q < CNT_N) ? cnt_q[XAW-1:0] : '0;
   assign w_raddr = BAW'(int'(grp_q) * N + int'(rd_col));

   always_ff @(posedge clk) begin
      if (x_we) x_mem[cnt_q[XAW-1:0]] <= data_in;
      x_rd <= x_mem[rd_col];
   end

   generate
      for (genvar gi = 0; gi < P; gi++) begin : g_lane
         logic signed [T-1:0]   w_mem [G*N];
         logic signed [T-1:0]   b_mem [G];
         logic signed [T-1:0]   w_rd, b_rd;
         logic signed [2*T-1:0] prod;
         acc_t                  acc_q, acc_d;

         always_ff @(posedge clk) begin
            if (w_hit && w_bank == gi) w_mem[w_waddr] <= cfg_data;
            if (b_hit && b_bank == gi) b_mem[b_waddr] <= cfg_data;
            w_rd <= w_mem[w_raddr];
            b_rd <= b_mem[grp_q];
         end

         assign prod = x_rd * w_rd;

         // Read data for column c lands in cycle c+1; the first product seeds the bias.
         always_comb begin
            acc_d = acc_q;
            if (state_q == COMPUTE && cnt_q != '0 && cnt_q <= CNT_N) begin
               if (cnt_q == CNT_ONE) acc_d = (acc_t'(b_rd) <<< FRAC) + acc_t'(prod);
               else                  acc_d = acc_q + acc_t'(prod);
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) acc_q <= '0;
            else       acc_q <= acc_d;
         end

         assign res[gi] = fmt(acc_q);
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      grp_d      = grp_q;
      lane_d     = lane_q;
      busy_d     = busy_q;
      m_valid_d  = m_valid_q;
      data_out_d = data_out_q;
      x_we       = 1'b0;
      case (state_q)
         LOAD_X: begin
            if (s_valid && s_ready) begin
               x_we   = 1'b1;
               busy_d = 1'b1;
               if (cnt_q == CNT_XLAST) begin
                  cnt_d   = '0;
                  grp_d   = '0;
                  state_d = COMPUTE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         COMPUTE: begin
            if (cnt_q == CNT_CLAST) begin
               cnt_d   = '0;
               lane_d  = '0;
               state_d = OUTPUT;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         OUTPUT: begin
            // Output word is registered, so the lane being loaded is the post-handshake one.
            if (m_valid_q && m_ready && lane_q == LANE_LAST) begin
               m_valid_d = 1'b0;
               lane_d    = '0;
               if (grp_q == GRP_LAST) begin
                  state_d = LOAD_X;
                  busy_d  = 1'b0;
               end else begin
                  grp_d   = grp_q + GW'(1);
                  state_d = COMPUTE;
               end
            end else begin
               if (m_valid_q && m_ready) lane_d = lane_q + LW'(1);
               m_valid_d  = 1'b1;
               data_out_d = res[lane_d];
            end
         end
         default: state_d = LOAD_X;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= LOAD_X;
         cnt_q      <= '0;
         grp_q      <= '0;
         lane_q     <= '0;
         busy_q     <= 1'b0;
         m_valid_q  <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         grp_q      <= grp_d;
         lane_q     <= lane_d;
         busy_q     <= busy_d;
         m_valid_q  <= m_valid_d;
         data_out_q <= data_out_d;
      end
   end

endmodule

// File: tb/tb_fc_layer_par.sv
// Directed bench for fc_layer_par: three instances (ReLU, linear, FRAC=4 ReLU) share one stimulus stream
// and are each checked against hand-computed results.
module tb_fc_layer_par;
   localparam int M = 4, N = 4, T = 16, P = 2, AW = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic s_valid = 1'b0, m_ready = 1'b1, cfg_we = 1'b0, cfg_sel = 1'b0;
   logic [T-1:0]  data_in = '0, cfg_data = '0;
   logic [AW-1:0] cfg_addr = '0;
   logic          sr [3];
   logic          mv [3];
   logic          bz [3];
   logic [T-1:0]  dout [3];

   int checks = 0, errors = 0, cyc = 0, k_last = 0, vec = 0;
   int xv [4];
   int bv [4];
   int e_r [4];
   int e_l [4];
   int e_f [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fc_layer_par #(.M(M), .N(N), .T(T), .P(P), .FRAC(0), .RELU(1)) u_relu (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(sr[0]), .data_in(data_in),
      .m_valid(mv[0]), .m_ready(m_ready), .data_out(dout[0]), .cfg_we(cfg_we),
      .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(bz[0]));
   fc_layer_par #(.M(M), .N(N), .T(T), .P(P), .FRAC(0), .RELU(0)) u_lin (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(sr[1]), .data_in(data_in),
      .m_valid(mv[1]), .m_ready(m_ready), .data_out(dout[1]), .cfg_we(cfg_we),
      .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(bz[1]));
   fc_layer_par #(.M(M), .N(N), .T(T), .P(P), .FRAC(4), .RELU(1)) u_frac (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(sr[2]), .data_in(data_in),
      .m_valid(mv[2]), .m_ready(m_ready), .data_out(dout[2]), .cfg_we(cfg_we),
      .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(bz[2]));

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cfg_write(input logic sel, input int addr, input int val);
      cfg_we   = 1'b1;
      cfg_sel  = sel;
      cfg_addr = AW'(addr);
      cfg_data = T'(val);
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic load_w(input int diag, input int off);
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++)
            cfg_write(1'b0, r*N + c, (r == c) ? diag : off);
   endtask

   task automatic load_b();
      for (int r = 0; r < M; r++) cfg_write(1'b1, r, bv[r]);
   endtask

   task automatic send_x();
      for (int i = 0; i < N; i++) begin
         int guard;
         guard = 0;
         s_valid = 1'b1;
         data_in = T'(xv[i]);
         while (!sr[0] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
         end
         check("s_ready_wait", int'(sr[0]), 1);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      k_last  = cyc;
   endtask

   task automatic collect(input int n, input int stall_idx, input bit lat_chk);
      int got, guard;
      bit stalled;
      logic [T-1:0] snap;
      int y [3][4];
      got = 0; guard = 0; stalled = 1'b0;
      for (int d = 0; d < 3; d++) for (int i = 0; i < 4; i++) y[d][i] = 0;
      while (got < n && guard < 100) begin
         m_ready = 1'b1;
         if (mv[0]) begin
            if (got == 0 && lat_chk) check("first_valid_latency", cyc - k_last, N + 3);
            if (got == stall_idx && !stalled) begin
               m_ready = 1'b0;
               snap = dout[0];
               repeat (5) begin
                  @(posedge clk); #1;
                  check("bp_valid_held", int'(mv[0]), 1);
                  check("bp_data_stable", int'(dout[0]), int'(snap));
               end
               stalled = 1'b1;
               m_ready = 1'b1;
            end
            for (int d = 0; d < 3; d++) y[d][got] = int'($signed(dout[d]));
            got++;
         end
         @(posedge clk); #1;
         guard++;
      end
      check("words_received", got, n);
      for (int i = 0; i < n; i++) begin
         check($sformatf("v%0d_y%0d_relu", vec, i), y[0][i], e_r[i]);
         check($sformatf("v%0d_y%0d_lin", vec, i), y[1][i], e_l[i]);
         check($sformatf("v%0d_y%0d_frac", vec, i), y[2][i], e_f[i]);
      end
      $display("vector %0d: relu %0d %0d %0d %0d | lin %0d %0d %0d %0d | frac %0d %0d %0d %0d", vec,
               y[0][0], y[0][1], y[0][2], y[0][3], y[1][0], y[1][1], y[1][2], y[1][3],
               y[2][0], y[2][1], y[2][2], y[2][3]);
      vec++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got 0 expected 1");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", int'(sr[0]), 0);
      check("rst_m_valid", int'(mv[0]), 0);
      check("rst_data_out", int'(dout[0]), 0);
      check("rst_busy", int'(bz[0]), 0);
      reset = 1'b0;
      #1;
      check("release_s_ready", int'(sr[0]), 1);
      @(posedge clk); #1;

      // Identity weights, zero bias
      load_w(1, 0);
      bv = '{0, 0, 0, 0}; load_b();
      xv = '{1, 2, 3, 4};
      e_r = '{1, 2, 3, 4}; e_l = '{1, 2, 3, 4}; e_f = '{0, 0, 0, 0};
      send_x();
      check("busy_during", int'(bz[0]), 1);
      collect(4, -1, 1'b1);
      check("busy_clear", int'(bz[0]), 0);

      // Negative bias: ReLU clamps, linear passes through
      bv = '{-10, 0, 0, -5}; load_b();
      e_r = '{0, 2, 3, 0}; e_l = '{-9, 2, 3, -1}; e_f = '{0, 0, 0, 0};
      send_x(); collect(4, -1, 1'b0);

      // Positive saturation
      load_w(32767, 32767);
      bv = '{32767, 32767, 32767, 32767}; load_b();
      xv = '{32767, 32767, 32767, 32767};
      e_r = '{32767, 32767, 32767, 32767}; e_l = e_r; e_f = e_r;
      send_x(); collect(4, -1, 1'b0);

      // Negative saturation
      load_w(-32768, -32768);
      e_r = '{0, 0, 0, 0}; e_l = '{-32768, -32768, -32768, -32768}; e_f = '{0, 0, 0, 0};
      send_x(); collect(4, -1, 1'b0);

      // FRAC scaling plus 5-cycle backpressure on the second word
      load_w(16, 0);
      bv = '{0, 0, 0, 0}; load_b();
      xv = '{48, 32, -16, 5};
      e_r = '{768, 512, 0, 80}; e_l = '{768, 512, -256, 80}; e_f = '{48, 32, 0, 5};
      send_x(); collect(4, 1, 1'b0);

      // Coefficient write while busy is dropped, and idle write takes effect
      xv = '{1, 0, 0, 0};
      e_r = '{16, 0, 0, 0}; e_l = e_r; e_f = '{1, 0, 0, 0};
      send_x();
      check("busy_before_cfg", int'(bz[0]), 1);
      cfg_write(1'b0, 0, 99);
      collect(4, -1, 1'b0);
      send_x(); collect(4, -1, 1'b0);
      cfg_write(1'b0, 0, 99);
      e_r = '{99, 0, 0, 0}; e_l = e_r; e_f = '{6, 0, 0, 0};
      send_x(); collect(4, -1, 1'b0);

      // Reset during group 1 compute, then a fresh vector with retained coefficients
      xv = '{1, 2, 3, 4};
      e_r = '{99, 32, 48, 64}; e_l = e_r; e_f = '{6, 2, 3, 4};
      send_x(); collect(2, -1, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      check("abort_m_valid", int'(mv[0]), 0);
      check("abort_busy", int'(bz[0]), 0);
      check("abort_s_ready", int'(sr[0]), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("abort_release_s_ready", int'(sr[0]), 1);
      @(posedge clk); #1;
      send_x(); collect(4, -1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
